// File: rtl/segment_readback_encoder.sv
// Recovers hex digit values from a multiplexed active-low 7-segment bus by
// waiting for each {select, segments} pattern to hold steady before capturing it.

module segment_readback_digit (
   input  logic       clock,
   input  logic       reset,
   input  logic       wr,
   input  logic       hit,
   input  logic       off,
   input  logic [3:0] val,
   output logic [3:0] nibble,
   output logic       valid,
   output logic       blank,
   output logic       err
);
   // Non-table patterns keep the last good nibble so readback still shows history.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         nibble <= 4'h0;
         valid  <= 1'b0;
         blank  <= 1'b0;
         err    <= 1'b0;
      end else if (wr) begin
         valid <= hit;
         blank <= off;
         err   <= ~hit & ~off;
         if (hit)
            nibble <= val;
         else if (off)
            nibble <= 4'h0;
      end
   end
endmodule

module segment_readback_encoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [0:6]              segIn,
   input  logic [NUM_DIGITS-1:0]   digitSel,
   output logic [4*NUM_DIGITS-1:0] hexOut,
   output logic [NUM_DIGITS-1:0]   validMask,
   output logic [NUM_DIGITS-1:0]   blankMask,
   output logic [NUM_DIGITS-1:0]   errorMask,
   output logic                    update,
   output logic [2:0]              updateDigit
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic [CW-1:0]           cnt_inc;
   logic [0:6]              s_seg, p_seg;
   logic [NUM_DIGITS-1:0]   s_sel, p_sel;
   logic                    seen, multi, one_hot, same, capture;
   logic [2:0]              idx;
   logic                    dec_hit, dec_off;
   logic [3:0]              dec_val;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s_seg <= '0;
         s_sel <= '0;
      end else begin
         s_seg <= segIn;
         s_sel <= digitSel;
      end
   end

   always_comb begin
      seen  = 1'b0;
      multi = 1'b0;
      idx   = 3'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (s_sel[i]) begin
            if (seen)
               multi = 1'b1;
            seen = 1'b1;
            idx  = 3'(i);
         end
      end
      one_hot = seen & ~multi;
      same    = (s_sel == p_sel) && (s_seg == p_seg);
      cnt_inc = cnt + CW'(1);
      capture = one_hot && same && (state == COUNT) && (cnt_inc == CW'(STABLE_CYCLES));
   end

   always_comb begin
      dec_hit = 1'b1;
      dec_val = 4'h0;
      dec_off = (s_seg == 7'b1111111);
      case (s_seg)
         7'b0000001: dec_val = 4'h0;
         7'b1001111: dec_val = 4'h1;
         7'b0010010: dec_val = 4'h2;
         7'b0000110: dec_val = 4'h3;
         7'b1001100: dec_val = 4'h4;
         7'b0100100: dec_val = 4'h5;
         7'b0100000: dec_val = 4'h6;
         7'b0001111: dec_val = 4'h7;
         7'b0000000: dec_val = 4'h8;
         7'b0000100: dec_val = 4'h9;
         7'b0001000: dec_val = 4'hA;
         7'b1100000: dec_val = 4'hB;
         7'b0110001: dec_val = 4'hC;
         7'b1000010: dec_val = 4'hD;
         7'b0110000: dec_val = 4'hE;
         7'b0111000: dec_val = 4'hF;
         default:    dec_hit = 1'b0;
      endcase
   end

   // Any change of select or segments starts a new stable episode from any state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         p_seg       <= '0;
         p_sel       <= '0;
         update      <= 1'b0;
         updateDigit <= 3'd0;
      end else begin
         update <= 1'b0;
         if (!one_hot) begin
            state <= IDLE;
            cnt   <= '0;
            p_seg <= '0;
            p_sel <= '0;
         end else if (!same) begin
            state <= COUNT;
            cnt   <= CW'(1);
            p_seg <= s_seg;
            p_sel <= s_sel;
         end else if (state == COUNT) begin
            cnt <= cnt_inc;
            if (capture) begin
               state       <= HOLD;
               update      <= 1'b1;
               updateDigit <= idx;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      segment_readback_digit u_digit (
         .clock  (clock),
         .reset  (reset),
         .wr     (capture && (idx == 3'(g))),
         .hit    (dec_hit),
         .off    (dec_off),
         .val    (dec_val),
         .nibble (hexOut[4*g +: 4]),
         .valid  (validMask[g]),
         .blank  (blankMask[g]),
         .err    (errorMask[g])
      );
   end
endmodule

// File: tb/tb_segment_readback_encoder.sv
// Bench for segment_readback_encoder: directed scenarios plus random episodes,
// checked each cycle against a run-length model of the segment bus.

module tb_segment_readback_encoder;
   localparam int ND = 4;
   localparam int SC = 4;
   localparam int OW = 7 * ND + 4;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [0:6]      segIn = '0;
   logic [ND-1:0]   digitSel = '0;
   logic [4*ND-1:0] hexOut;
   logic [ND-1:0]   validMask, blankMask, errorMask;
   logic            update;
   logic [2:0]      updateDigit;
   logic [OW-1:0]   obs;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   segment_readback_encoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clock(clock), .reset(reset), .segIn(segIn), .digitSel(digitSel),
      .hexOut(hexOut), .validMask(validMask), .blankMask(blankMask),
      .errorMask(errorMask), .update(update), .updateDigit(updateDigit)
   );

   assign obs = {hexOut, validMask, blankMask, errorMask, update, updateDigit};

   // Glyphs written a..g left to right, 0 = lit.
   logic [6:0] tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   // Model: count consecutive identical one-hot samples; an episode that
   // reaches SC samples is captured on the following edge.
   logic [3:0]    m_hex [ND];
   logic [ND-1:0] m_valid, m_blank, m_err;
   logic          m_update;
   logic [2:0]    m_digit;
   int            m_run;
   logic [6:0]    m_seg;
   logic [ND-1:0] m_sel;

   function automatic int lookup(input logic [6:0] p);
      if (p == 7'b1111111) return 16;
      for (int v = 0; v < 16; v++)
         if (tbl[v] == p) return v;
      return -1;
   endfunction

   function automatic int onehot_idx(input logic [ND-1:0] s);
      if ($countones(s) != 1) return -1;
      for (int i = 0; i < ND; i++)
         if (s[i]) return i;
      return -1;
   endfunction

   function automatic logic [OW-1:0] m_all();
      logic [4*ND-1:0] h;
      for (int i = 0; i < ND; i++) h[4*i +: 4] = m_hex[i];
      return {h, m_valid, m_blank, m_err, m_update, m_digit};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < ND; i++) m_hex[i] = 4'h0;
      m_valid = '0; m_blank = '0; m_err = '0;
      m_update = 1'b0; m_digit = 3'd0;
      m_run = 0; m_seg = '0; m_sel = '0;
   endtask

   task automatic step(input logic [6:0] seg, input logic [ND-1:0] sel);
      int i, v;
      segIn    = seg;
      digitSel = sel;
      @(posedge clock);
      m_update = 1'b0;
      if (m_run == SC) begin
         i = onehot_idx(m_sel);
         v = lookup(m_seg);
         m_update = 1'b1;
         m_digit  = 3'(i);
         if (v >= 0 && v < 16) begin
            m_hex[i] = 4'(v); m_valid[i] = 1'b1; m_blank[i] = 1'b0; m_err[i] = 1'b0;
         end else if (v == 16) begin
            m_hex[i] = 4'h0; m_valid[i] = 1'b0; m_blank[i] = 1'b1; m_err[i] = 1'b0;
         end else begin
            m_valid[i] = 1'b0; m_blank[i] = 1'b0; m_err[i] = 1'b1;
         end
      end
      if (onehot_idx(sel) < 0)
         m_run = 0;
      else if (m_run > 0 && sel == m_sel && seg == m_seg) begin
         if (m_run <= SC) m_run++;
      end else
         m_run = 1;
      m_sel = sel;
      m_seg = seg;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      model_clear();
      repeat (2) @(posedge clock);
      #1;
      tests++;
      if (obs !== '0) begin
         fails++; $display("FAIL reset_state: got %h want 0", obs);
      end
      reset = 1'b0;
   endtask

   task automatic test_single();
      int n = 0, at = 0;
      for (int c = 1; c <= 10; c++) begin
         step(tbl[2], 4'b0001);
         tests++;
         if (obs !== m_all()) begin
            fails++; $display("FAIL single_c%0d: got %h want %h", c, obs, m_all());
         end
         if (update) begin n++; at = c; end
      end
      tests++;
      if (n !== 1 || at !== 5) begin
         fails++; $display("FAIL single_pulse: got %0d pulses at %0d want 1 at 5", n, at);
      end
      tests++;
      if (hexOut[3:0] !== 4'h2 || validMask !== 4'b0001) begin
         fails++; $display("FAIL single_value: got %h/%b want 2/0001", hexOut[3:0], validMask);
      end
   endtask

   task automatic test_scan();
      int vals [4] = '{5, 10, 13, 15};
      int digs [$];
      logic [ND-1:0] s;
      for (int d = 0; d < 4; d++) begin
         s = '0; s[d] = 1'b1;
         for (int c = 0; c < 6 + (d == 3 ? 2 : 0); c++) begin
            step(tbl[vals[d]], s);
            tests++;
            if (obs !== m_all()) begin
               fails++; $display("FAIL scan_d%0d_c%0d: got %h want %h", d, c, obs, m_all());
            end
            if (update) digs.push_back(int'(updateDigit));
         end
      end
      tests++;
      if (hexOut !== 16'hFDA5 || validMask !== 4'b1111) begin
         fails++; $display("FAIL scan_value: got %h/%b want FDA5/1111", hexOut, validMask);
      end
      tests++;
      if (digs.size() != 4 || digs[0] != 0 || digs[1] != 1 || digs[2] != 2 || digs[3] != 3) begin
         fails++; $display("FAIL scan_pulses: got %0d pulses %p want 0,1,2,3", digs.size(), digs);
      end
   endtask

   task automatic test_blank_err();
      for (int c = 0; c < 16; c++) begin
         step(c < 8 ? 7'b1111111 : 7'b1111110, 4'b0010);
         tests++;
         if (obs !== m_all()) begin
            fails++; $display("FAIL blank_err_c%0d: got %h want %h", c, obs, m_all());
         end
         if (c == 7) begin
            tests++;
            if (blankMask !== 4'b0010 || hexOut[7:4] !== 4'h0 || validMask[1] !== 1'b0) begin
               fails++; $display("FAIL blank_state: got b=%b n=%h v=%b", blankMask, hexOut[7:4], validMask);
            end
         end
      end
      tests++;
      if (errorMask !== 4'b0010 || blankMask !== 4'b0000 || hexOut[7:4] !== 4'h0 || validMask[1] !== 1'b0) begin
         fails++; $display("FAIL err_state: got e=%b b=%b n=%h v=%b want 0010 0000 0 0",
                           errorMask, blankMask, hexOut[7:4], validMask);
      end
   endtask

   task automatic test_glitch();
      int n = 0, at = 0;
      for (int c = 1; c <= 11; c++) begin
         step((c == 4) ? tbl[9] : tbl[8], 4'b0100);
         tests++;
         if (obs !== m_all()) begin
            fails++; $display("FAIL glitch_c%0d: got %h want %h", c, obs, m_all());
         end
         if (update) begin n++; at = c; end
      end
      tests++;
      if (n !== 1 || at !== 9 || hexOut[11:8] !== 4'h8) begin
         fails++; $display("FAIL glitch_result: got %0d pulses at %0d nibble %h want 1 at 9 nibble 8",
                           n, at, hexOut[11:8]);
      end
   endtask

   task automatic test_invalid_sel();
      logic [OW-1:0] held;
      held = m_all();
      for (int c = 0; c < 40; c++) begin
         step(7'($urandom), c < 20 ? 4'b0011 : 4'b0000);
         tests++;
         if (obs !== held) begin
            fails++; $display("FAIL invalid_sel_c%0d: got %h want %h", c, obs, held);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n = 0, at = 0;
      for (int c = 0; c < 4; c++) step(tbl[3], 4'b1000);
      reset = 1'b1;
      model_clear();
      #3;
      tests++;
      if (obs !== '0) begin
         fails++; $display("FAIL reset_mid: got %h want 0", obs);
      end
      reset = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         step(tbl[3], 4'b1000);
         tests++;
         if (obs !== m_all()) begin
            fails++; $display("FAIL reset_mid_c%0d: got %h want %h", c, obs, m_all());
         end
         if (update) begin n++; at = c; end
      end
      tests++;
      if (n !== 1 || at !== 5 || hexOut !== 16'h3000 || validMask !== 4'b1000) begin
         fails++; $display("FAIL reset_mid_recap: got %0d at %0d hex %h v %b want 1 at 5 3000 1000",
                           n, at, hexOut, validMask);
      end
   endtask

   task automatic test_random();
      logic [ND-1:0] s;
      logic [6:0]    p;
      int            r, len;
      for (int e = 0; e < 250; e++) begin
         r = $urandom_range(0, 99);
         if (r < 85) begin s = '0; s[$urandom_range(0, ND-1)] = 1'b1; end
         else        s = ND'($urandom_range(0, (1 << ND) - 1));
         r = $urandom_range(0, 99);
         if (r < 60)      p = tbl[$urandom_range(0, 15)];
         else if (r < 75) p = 7'b1111111;
         else             p = 7'($urandom);
         len = $urandom_range(1, 7);
         for (int c = 0; c < len; c++) begin
            step(p, s);
            tests++;
            if (obs !== m_all()) begin
               fails++; $display("FAIL random_e%0d_c%0d: got %h want %h", e, c, obs, m_all());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_scan();
      test_blank_err();
      test_glitch();
      test_invalid_sel();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
